// File: rtl/i2s_clk_ctrl.sv
// i2s_clk_ctrl: I2S master clock controller.
// Divides clk into sclk/lrclk, starts and stops only on frame boundaries,
// pulses frame_start at each frame start.
// Optional feature macro: I2S_CLK_CTRL_UNDERRUN_EN builds the saturating
// TX underrun counter; without it underrun_cnt is tied to 0.
module i2s_clk_ctrl #(
  parameter int unsigned DW       = 24,
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        busy,
  output logic        sclk,
  output logic        lrclk,
  output logic        frame_start,
  input  logic        tx_rd_en,
  input  logic        tx_rd_valid,
  input  logic        clr_underrun,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned HALF     = SCLK_DIV / 2;
  localparam int unsigned DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W    = $clog2(2 * DW);
  localparam int unsigned LAST_BIT = 2 * DW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_next;
  logic               sclk_next;
  logic               lrclk_next;
  logic               fs_next;
  logic               tick;
  logic               fall;
  logic               wrap;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output logic; en is sampled at the wrap edge to
  // decide between another frame and going idle.
  always_comb begin
    state_next = state;
    div_next   = '0;
    bit_next   = '0;
    sclk_next  = 1'b0;
    lrclk_next = 1'b0;
    fs_next    = 1'b0;
    tick       = 1'b0;
    fall       = 1'b0;
    wrap       = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          fs_next    = 1'b1;
        end
      end
      RUN, DRAIN: begin
        tick       = (div_cnt == DIV_W'(HALF - 1));
        fall       = tick & sclk;
        wrap       = fall & (bit_cnt == BIT_W'(LAST_BIT));
        div_next   = tick ? '0 : div_cnt + DIV_W'(1);
        sclk_next  = tick ? ~sclk : sclk;
        bit_next   = fall ? (wrap ? '0 : bit_cnt + BIT_W'(1)) : bit_cnt;
        lrclk_next = (bit_next >= BIT_W'(DW));
        if (wrap) begin
          if (en) begin
            state_next = RUN;
            fs_next    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = en ? RUN : DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered clock outputs, counters and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sclk        <= 1'b0;
      lrclk       <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      bit_cnt     <= bit_next;
      sclk        <= sclk_next;
      lrclk       <= lrclk_next;
      busy        <= (state_next != IDLE);
      frame_start <= fs_next;
    end
  end

`ifdef I2S_CLK_CTRL_UNDERRUN_EN
  logic underrun_evt;

  assign underrun_evt = tx_rd_en & ~tx_rd_valid & busy;

  // Saturating underrun counter; clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || clr_underrun) begin
      underrun_cnt <= '0;
    end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  logic unused_underrun_in;

  // Detector not built: counter reads 0 and its inputs are ignored.
  assign underrun_cnt       = '0;
  assign unused_underrun_in = &{1'b0, tx_rd_en, tx_rd_valid, clr_underrun};
`endif

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// tb_i2s_clk_ctrl: scoreboard bench for i2s_clk_ctrl (DW=4, SCLK_DIV=4).
// A frame-phase reference model pushes expected outputs per clock edge;
// a monitor pops and compares them after each edge.
module tb_i2s_clk_ctrl;

  localparam int unsigned DW       = 4;
  localparam int unsigned SCLK_DIV = 4;
  localparam int unsigned HALF     = SCLK_DIV / 2;
  localparam int unsigned FRAME    = 2 * DW * SCLK_DIV;
  localparam int unsigned LR_CYC   = DW * SCLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        busy;
  logic        sclk;
  logic        lrclk;
  logic        frame_start;
  logic        tx_rd_en = 1'b0;
  logic        tx_rd_valid = 1'b0;
  logic        clr_underrun = 1'b0;
  logic [15:0] underrun_cnt;

  typedef struct packed {
    logic        sclk;
    logic        lrclk;
    logic        busy;
    logic        fs;
    logic [15:0] ucnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  bit          m_active = 1'b0;
  int unsigned m_phase = 0;
  logic [15:0] m_ucnt = 16'h0;

  i2s_clk_ctrl #(.DW(DW), .SCLK_DIV(SCLK_DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .busy         (busy),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .frame_start  (frame_start),
    .tx_rd_en     (tx_rd_en),
    .tx_rd_valid  (tx_rd_valid),
    .clr_underrun (clr_underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply current inputs for one clock edge and queue the expected result.
  task automatic step();
    exp_t e;
`ifdef I2S_CLK_CTRL_UNDERRUN_EN
    logic evt;
    evt = m_active && tx_rd_en && !tx_rd_valid;
`endif
    e = '0;
    if (rst) begin
      m_active = 1'b0;
      m_phase  = 0;
      m_ucnt   = 16'h0;
    end else begin
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_phase  = 0;
          e.fs     = 1'b1;
        end
      end else begin
        m_phase++;
        if (m_phase == FRAME) begin
          m_phase = 0;
          if (en) e.fs = 1'b1;
          else    m_active = 1'b0;
        end
      end
`ifdef I2S_CLK_CTRL_UNDERRUN_EN
      if (clr_underrun)                   m_ucnt = 16'h0;
      else if (evt && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
`endif
    end
    e.busy  = m_active;
    e.sclk  = m_active && (((m_phase / HALF) % 2) == 1);
    e.lrclk = m_active && (m_phase >= LR_CYC);
    e.ucnt  = m_ucnt;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  // Advance until the model reaches phase p of an active frame (bounded).
  task automatic run_to_phase(input int unsigned p);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_active && m_phase == p) return;
      step();
    end
    check("phase_reach", 32'(m_phase), 32'(p));
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sclk",         32'(sclk),         32'(e.sclk));
        check("lrclk",        32'(lrclk),        32'(e.lrclk));
        check("busy",         32'(busy),         32'(e.busy));
        check("frame_start",  32'(frame_start),  32'(e.fs));
        check("underrun_cnt", 32'(underrun_cnt), 32'(e.ucnt));
      end
    end
  end

  initial begin
    // Reset and idle.
    run(5);
    rst = 1'b0;
    run(20);

    // Start and run three frames.
    en = 1'b1;
    run(3 * FRAME);

    // Clean stop: drop en mid-frame, port finishes the frame and idles.
    run_to_phase(10);
    en = 1'b0;
    run(FRAME + 8);

    // Drain cancel: drop at 10, restore at 20, next frame follows seamlessly.
    en = 1'b1;
    run(1);
    run_to_phase(10);
    en = 1'b0;
    run_to_phase(20);
    en = 1'b1;
    run(FRAME + 5);

    // Underrun events, clear-vs-event priority, valid reads.
    run_to_phase(3);
    for (int i = 0; i < 3; i++) begin
      tx_rd_en    = 1'b1;
      tx_rd_valid = 1'b0;
      step();
      tx_rd_en    = 1'b0;
      run(3);
    end
    tx_rd_en     = 1'b1;
    clr_underrun = 1'b1;
    step();
    tx_rd_en     = 1'b0;
    clr_underrun = 1'b0;
    run(3);
    tx_rd_en    = 1'b1;
    tx_rd_valid = 1'b1;
    run(2);
    tx_rd_en    = 1'b0;
    tx_rd_valid = 1'b0;

    // Events while idle must not count.
    en = 1'b0;
    run(FRAME + 2);
    tx_rd_en = 1'b1;
    run(3);
    tx_rd_en = 1'b0;

`ifdef I2S_CLK_CTRL_UNDERRUN_EN
    // Saturation.
    en       = 1'b1;
    tx_rd_en = 1'b1;
    run(65537 + 3);
    tx_rd_en = 1'b0;
`endif

    // Reset mid-frame.
    en = 1'b1;
    run(1);
    run_to_phase(13);
    rst = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
